ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the send side of the keyboard link whose receive side is the PS2Controller. It sends one command byte to the keyboard, for example 0xED followed by the LED mask, or 0xFF reset. It performs the clock-inhibit / request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device line-ACK. It drives the open-drain PS/2 lines at top level, alongside the receiver, and holds the receiver off while a transfer is in progress.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_filter.sv | 64 ++++++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host link.
//   tx_state_t   - host transmitter FSM state encoding
//   CMD_*/RESP_* - keyboard command and response bytes
//   odd_parity   - PS/2 parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] RESP_RESEND  = 8'hFE;

    // Parity bit makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: input conditioning for the PS/2 pads.
//   clk, reset   - system clock, synchronous active-high reset
//   i_ps2_clk    - raw clock pad (asynchronous)
//   i_ps2_data   - raw data pad (asynchronous)
//   o_clk_level  - synchronized, debounced clock level
//   o_clk_fall   - one-cycle pulse on a debounced 1->0 clock transition
//   o_data_sync  - synchronized data level
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_level,
    output logic o_clk_fall,
    output logic o_data_sync
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             r_clk_s1, r_clk_s2;
    logic             r_dat_s1, r_dat_s2;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // Idle bus level is high, so the synchronizers and filter reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_level  <= 1'b1;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            // r_cnt counts consecutive samples differing from the accepted
            // level; any sample matching it restarts the run.
            if (r_clk_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_level <= r_clk_s2;
                r_fall  <= ~r_clk_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_level = r_level;
    assign o_clk_fall  = r_fall;
    assign o_data_sync = r_dat_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
//   clk, reset          - system clock, synchronous active-high reset
//   tx_valid/tx_data    - command byte request; accepted when tx_ready
//   tx_ready            - idle, able to accept a byte
//   ps2_clk_in/data_in  - raw pad values (asynchronous)
//   ps2_*_drive_low     - registered open-drain pull-down enables
//   busy                - transfer in progress (receiver inhibit)
//   tx_done             - one-cycle end-of-transfer pulse
//   tx_ack_ok/tx_error  - qualified by tx_done: device ACK seen / timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ       = 100_000_000,
    parameter int unsigned INHIBIT_CYCLES    = 12_000,
    parameter int unsigned FIRST_EDGE_CYCLES = 1_500_000,
    parameter int unsigned EDGE_GAP_CYCLES   = 200_000,
    parameter int unsigned FILTER_LEN        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    if (CLK_FREQ_HZ == 0) begin : g_freq_check
        $error("CLK_FREQ_HZ must be nonzero");
    end

    tx_state_t   r_state;
    logic [7:0]  r_data;
    logic        r_par;
    logic [3:0]  r_bitn;
    logic [31:0] r_cnt;
    logic        r_clk_low;
    logic        r_data_low;
    logic        r_ack;
    logic        r_err;

    logic        w_clk_level;
    logic        w_clk_fall;
    logic        w_data_sync;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_clk_level (w_clk_level),
        .o_clk_fall  (w_clk_fall),
        .o_data_sync (w_data_sync)
    );

    // r_cnt serves as the inhibit timer and then as the edge timeout; both
    // are loaded with N-1 so the action lands exactly N cycles after loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_bitn     <= '0;
            r_cnt      <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (tx_valid) begin
                        r_data    <= tx_data;
                        r_par     <= odd_parity(tx_data);
                        r_ack     <= 1'b0;
                        r_err     <= 1'b0;
                        r_clk_low <= 1'b1;
                        r_cnt     <= INHIBIT_CYCLES - 1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == '0) begin
                        r_clk_low  <= 1'b0;
                        r_data_low <= 1'b1;   // start bit
                        r_cnt      <= FIRST_EDGE_CYCLES - 1;
                        r_state    <= ST_RTS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RTS: begin
                    r_bitn  <= '0;
                    r_state <= ST_SHIFT;
                    if (r_cnt == '0) begin
                        timeout();
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // An edge in the same cycle as expiry is honoured.
                    if (w_clk_fall) begin
                        r_cnt <= EDGE_GAP_CYCLES - 1;
                        if (r_bitn < 4'd8) begin
                            r_data_low <= ~r_data[r_bitn[2:0]];
                        end else if (r_bitn == 4'd8) begin
                            r_data_low <= ~r_par;
                        end else begin
                            r_data_low <= 1'b0;   // stop bit
                            r_state    <= ST_ACK;
                        end
                        r_bitn <= r_bitn + 1'b1;
                    end else if (r_cnt == '0) begin
                        timeout();
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    if (w_clk_fall) begin
                        r_ack   <= ~w_data_sync;
                        r_cnt   <= EDGE_GAP_CYCLES - 1;
                        r_state <= ST_RELEASE;
                    end else if (r_cnt == '0) begin
                        timeout();
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (w_data_sync && w_clk_level) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == '0) begin
                        timeout();
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Overrides the next-state assignments made before the call.
    task automatic timeout();
        r_clk_low  <= 1'b0;
        r_data_low <= 1'b0;
        r_ack      <= 1'b0;
        r_err      <= 1'b1;
        r_state    <= ST_DONE;
    endtask

    assign ps2_clk_drive_low  = r_clk_low;
    assign ps2_data_drive_low = r_data_low;
    assign tx_done            = (r_state == ST_DONE);
    assign tx_ack_ok          = tx_done & r_ack;
    assign tx_error           = tx_done & r_err;
    assign busy               = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign tx_ready           = ~busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned P_INH   = 40;
    localparam int unsigned P_FIRST = 600;
    localparam int unsigned P_GAP   = 300;
    localparam int unsigned P_FILT  = 8;
    localparam int          H       = 40;   // device half clock period in cycles
    // pad change -> 2 sync + P_FILT filter + 1 fall register -> FSM edge
    localparam int          FALL_LAT = 2 + P_FILT + 1;

    typedef struct {
        logic ack;
        logic err;
        bit   chk;
        int   delay;
    } done_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
    logic       pad_clk, pad_data;

    assign pad_clk  = dev_clk & ~ps2_clk_drive_low & ~glitch;
    assign pad_data = dev_data & ~ps2_data_drive_low;

    ps2_host_tx #(
        .CLK_FREQ_HZ       (100_000_000),
        .INHIBIT_CYCLES    (P_INH),
        .FIRST_EDGE_CYCLES (P_FIRST),
        .EDGE_GAP_CYCLES   (P_GAP),
        .FILTER_LEN        (P_FILT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (pad_clk),
        .ps2_data_in        (pad_data),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .busy               (busy),
        .tx_done            (tx_done),
        .tx_ack_ok          (tx_ack_ok),
        .tx_error           (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_ref  = 0;

    done_t      exp_done_q[$];
    logic [9:0] exp_frame_q[$];
    logic [9:0] obs_frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops expectations whenever the DUT reports completion or the
    // device model delivers a captured frame.
    done_t      m_e;
    logic [9:0] m_f;
    always @(negedge clk) begin
        if (!reset && tx_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                fail_now("unexpected_tx_done");
            end else begin
                m_e = exp_done_q.pop_front();
                check("tx_ack_ok", tx_ack_ok, m_e.ack);
                check("tx_error", tx_error, m_e.err);
                if (m_e.chk) check("done_latency", cyc - t_ref, m_e.delay);
            end
        end
        if (obs_frame_q.size() > 0) begin
            m_f = obs_frame_q.pop_front();
            if (exp_frame_q.size() == 0) fail_now("unexpected_frame");
            else check("frame_bits", m_f, exp_frame_q.pop_front());
        end
    end

    task automatic expect_done(input logic ack, input logic err, input bit chk, input int delay);
        done_t e;
        e.ack = ack; e.err = err; e.chk = chk; e.delay = delay;
        exp_done_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        check("tx_ready_before_accept", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    // Device model: observes inhibit/RTS, then issues nfalls clock pulses,
    // sampling host data at the end of each low phase; the 11th low phase
    // carries the ACK. A 3-cycle glitch may be injected in one high phase.
    task automatic device_xfer(input int nfalls, input bit do_ack, input int glitch_idx);
        int n;
        logic [9:0] bits;
        bits = '0;
        n = 0;
        while (ps2_clk_drive_low !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            fail_now("no_clock_inhibit");
            return;
        end
        n = 0;
        while (ps2_clk_drive_low === 1'b1 && n < 100000) begin
            n++; @(negedge clk);
        end
        check("inhibit_cycles", n, P_INH);
        check("start_bit_at_release", ps2_data_drive_low, 1'b1);
        t_ref = cyc;
        repeat (20) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10) dev_data = do_ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            t_ref = cyc;
            repeat (H) @(negedge clk);
            if (i < 10) bits[i] = pad_data;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            if (i == glitch_idx) begin
                repeat (10) @(negedge clk);
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        if (nfalls >= 10) obs_frame_q.push_back(bits);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_done_q.size() != 0 && n < 5000) begin
            @(negedge clk); n++;
        end
        if (n >= 5000) fail_now({name, "_tx_done_timeout"});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_clk_drive", ps2_clk_drive_low, 1'b0);
        check("reset_data_drive", ps2_data_drive_low, 1'b0);
        check("reset_tx_done", tx_done, 1'b0);
        check("reset_tx_ack_ok", tx_ack_ok, 1'b0);
        check("reset_tx_error", tx_error, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 0xED, bits 1,0,1,1,0,1,1,1 parity 1 stop 1, device ACKs
        exp_frame_q.push_back(10'h3ED);
        expect_done(1'b1, 1'b0, 1'b0, 0);
        send(CMD_SET_LEDS);
        device_xfer(11, 1'b1, -1);
        wait_done("t1");

        // 2: 0xF4, bits 0,0,1,0,1,1,1,1 parity 0, ACK withheld
        exp_frame_q.push_back(10'h2F4);
        expect_done(1'b0, 1'b0, 1'b0, 0);
        send(CMD_ENABLE);
        device_xfer(11, 1'b0, -1);
        wait_done("t2");

        // 3: device never clocks: error P_FIRST cycles after clock release
        expect_done(1'b0, 1'b1, 1'b1, P_FIRST);
        send(8'hA5);
        device_xfer(0, 1'b0, -1);
        wait_done("t3");
        check("t3_clk_released", ps2_clk_drive_low, 1'b0);
        check("t3_data_released", ps2_data_drive_low, 1'b0);
        check("t3_tx_ready", tx_ready, 1'b1);

        // 4: device stops after 4th fall: error P_GAP after that fall is seen
        expect_done(1'b0, 1'b1, 1'b1, FALL_LAT + P_GAP);
        send(8'h00);
        device_xfer(4, 1'b0, -1);
        wait_done("t4");
        check("t4_data_released", ps2_data_drive_low, 1'b0);

        // 5: reset after 5 falls aborts silently; next transfer is normal
        send(8'h55);
        device_xfer(5, 1'b0, -1);
        check("t5_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_clk_released", ps2_clk_drive_low, 1'b0);
        check("t5_data_released", ps2_data_drive_low, 1'b0);
        check("t5_busy_cleared", busy, 1'b0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        exp_frame_q.push_back(10'h3FF);
        expect_done(1'b1, 1'b0, 1'b0, 0);
        send(CMD_RESET);
        device_xfer(11, 1'b1, -1);
        wait_done("t5");

        // 6: second request while busy ignored; 3-cycle clock glitch ignored
        exp_frame_q.push_back(10'h3ED);
        expect_done(1'b1, 1'b0, 1'b0, 0);
        send(CMD_SET_LEDS);
        fork
            device_xfer(11, 1'b1, 3);
            begin
                repeat (5) @(negedge clk);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    check("t6_tx_ready_while_busy", tx_ready, 1'b0);
                end
                tx_valid = 1'b0;
            end
        join
        wait_done("t6");
        repeat (P_INH + 20) @(negedge clk);
        check("t6_no_second_transfer", ps2_clk_drive_low, 1'b0);
        check("t6_idle_after", busy, 1'b0);

        repeat (5) @(negedge clk);
        check("pending_tx_done", exp_done_q.size(), 0);
        check("pending_frames", exp_frame_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
